// File: rtl/fill_pkg.sv
// rtl/fill_pkg.sv - shared types and defaults for the fill sequencer
package fill_pkg;

  localparam int DEF_LEN_W     = 23;
  localparam int DEF_FILLNUM_W = 24;
  localparam int DEF_SETTLE    = 16;

  // Fill length / sample address type shared with the buffer writer.
  typedef logic [DEF_LEN_W-1:0] fill_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_READY,
    ST_ACQ,
    ST_DONE
  } fill_state_e;

endpackage

// File: rtl/fill_sequencer_sat_counter.sv
// rtl/fill_sequencer_sat_counter.sv - up-counter with clear, enable and saturating terminal flag
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != max_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == max_i);

endmodule

// File: rtl/fill_sequencer.sv
// rtl/fill_sequencer.sv - arm/settle/acquire sequencer answering the trigger manager
module fill_sequencer
  import fill_pkg::*;
#(
  parameter int LEN_W     = DEF_LEN_W,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int FILLNUM_W = DEF_FILLNUM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prepare,
  input  logic                 go,
  input  logic [LEN_W-1:0]     fill_len,
  input  logic                 buf_space_ok,
  output logic                 ready,
  output logic                 done,
  output logic                 acq_en,
  output logic [LEN_W-1:0]     sample_addr,
  output logic [FILLNUM_W-1:0] fill_num,
  output logic                 len_err,
  output logic                 seq_err
);

  localparam int                SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]  SET_MAX = SET_W'(SETTLE - 1);

  fill_state_e          state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 len_err_q, len_err_d;
  logic                 seq_err_q, seq_err_d;
  logic [FILLNUM_W-1:0] fill_num_q, fill_num_d;
  logic                 ready_q, done_q, acq_en_q;

  logic [SET_W-1:0]     settle_cnt;
  logic                 settle_term;
  logic [LEN_W-1:0]     addr_cnt;
  logic                 addr_term;

  // Settle timer runs only while armed and sits at zero otherwise.
  sat_counter #(.W(SET_W)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != ST_ARM),
    .en_i   (state_q == ST_ARM),
    .max_i  (SET_MAX),
    .cnt_o  (settle_cnt),
    .term_o (settle_term)
  );

  // Sample address runs 0..len-1 during acquisition; it doubles as the output register.
  sat_counter #(.W(LEN_W)) u_addr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != ST_ACQ),
    .en_i   (state_q == ST_ACQ),
    .max_i  (len_q - 1'b1),
    .cnt_o  (addr_cnt),
    .term_o (addr_term)
  );

  // Next-state, latched length, error flags and fill count.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    seq_err_d  = seq_err_q;
    fill_num_d = fill_num_q;
    if (prepare && go) begin
      seq_err_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (prepare) begin
          state_d   = ST_ARM;
          len_d     = (fill_len == '0) ? LEN_W'(1) : fill_len;
          len_err_d = (fill_len == '0);
        end else if (go) begin
          seq_err_d = 1'b1;
        end
      end
      ST_ARM: begin
        if (!prepare) begin
          state_d   = ST_IDLE;
          seq_err_d = 1'b1;
        end else begin
          if (go) begin
            seq_err_d = 1'b1;
          end
          if (settle_term && buf_space_ok) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (go) begin
          state_d = ST_ACQ;
        end else if (!prepare) begin
          state_d   = ST_IDLE;
          seq_err_d = 1'b1;
        end
      end
      ST_ACQ: begin
        if (addr_term) begin
          state_d    = ST_DONE;
          fill_num_d = fill_num_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_W'(1);
      len_err_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      fill_num_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      acq_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
      seq_err_q  <= seq_err_d;
      fill_num_q <= fill_num_d;
      ready_q    <= (state_d == ST_READY);
      done_q     <= (state_d == ST_DONE);
      acq_en_q   <= (state_d == ST_ACQ);
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign acq_en      = acq_en_q;
  assign sample_addr = addr_cnt;
  assign fill_num    = fill_num_q;
  assign len_err     = len_err_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// tb/tb_fill_sequencer.sv - scoreboard bench for fill_sequencer
module tb_fill_sequencer;

  localparam int LEN_W  = 8;
  localparam int SETTLE = 4;
  localparam int FNW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             prepare = 1'b0;
  logic             go = 1'b0;
  logic [LEN_W-1:0] fill_len = '0;
  logic             buf_space_ok = 1'b1;
  logic             ready, done, acq_en, len_err, seq_err;
  logic [LEN_W-1:0] sample_addr;
  logic [FNW-1:0]   fill_num;

  fill_sequencer #(.LEN_W(LEN_W), .SETTLE(SETTLE), .FILLNUM_W(FNW)) dut (
    .clk          (clk),
    .rst          (rst),
    .prepare      (prepare),
    .go           (go),
    .fill_len     (fill_len),
    .buf_space_ok (buf_space_ok),
    .ready        (ready),
    .done         (done),
    .acq_en       (acq_en),
    .sample_addr  (sample_addr),
    .fill_num     (fill_num),
    .len_err      (len_err),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int exp_addr_q[$];
  int exp_fill_q[$];
  int exp_fill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a sample or signals done.
  always @(negedge clk) begin
    if (!rst) begin
      if (acq_en) begin
        if (exp_addr_q.size() == 0) chk("strobe_unexpected", acq_en, 0);
        else chk("sample_addr", sample_addr, exp_addr_q.pop_front());
      end
      if (done) begin
        if (exp_fill_q.size() == 0) chk("done_unexpected", done, 0);
        else chk("fill_num", fill_num, exp_fill_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int edge_n);
    for (int i = 0; i < 200 && !ready; i++) tick();
    chk("ready_seen", ready, 1);
    edge_n = cyc;
  endtask

  task automatic do_acq(input int eff);
    int g;
    tick();
    chk("fill_num_before", fill_num, exp_fill);
    go = 1'b1;
    prepare = 1'b0;
    g = cyc;
    for (int i = 0; i < eff; i++) exp_addr_q.push_back(i);
    exp_fill = (exp_fill + 1) % (1 << FNW);
    exp_fill_q.push_back(exp_fill);
    tick();
    chk("ready_drop_on_go", ready, 0);
    for (int i = 0; i < 200 && !done; i++) tick();
    chk("done_seen", done, 1);
    chk("done_latency", cyc - g, eff + 1);
    go = 1'b0;
    chk("strobes_drained", exp_addr_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic run_fill(input int len_in);
    int p, r;
    fill_len = LEN_W'(len_in);
    buf_space_ok = 1'b1;
    prepare = 1'b1;
    p = cyc;
    wait_ready(r);
    chk("ready_latency", r - p, SETTLE + 1);
    do_acq((len_in == 0) ? 1 : len_in);
    chk("len_err", len_err, (len_in == 0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_acq_en"}, acq_en, 0);
    chk({tag, "_sample_addr"}, sample_addr, 0);
    chk({tag, "_fill_num"}, fill_num, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, rs;
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("reset");
    tick();
    tick();
    rst = 1'b0;

    // Basic fill: prepare after edge 10, ready at edge 15, eight strobes.
    while (cyc < 10) tick();
    run_fill(8);
    chk("basic_fill_num", fill_num, 1);
    chk("basic_seq_err", seq_err, 0);

    // Buffer stall: ready held off until buf_space_ok is seen.
    fill_len = 2;
    buf_space_ok = 1'b0;
    prepare = 1'b1;
    rs = 0;
    repeat (20) begin
      tick();
      if (ready) rs = 1;
    end
    chk("stall_ready_low", rs, 0);
    buf_space_ok = 1'b1;
    tick();
    chk("stall_ready_rise", ready, 1);
    do_acq(2);

    // Zero length then a normal length clears len_err.
    run_fill(0);
    run_fill(3);
    chk("seq_err_clean", seq_err, 0);

    // go pulsed in IDLE.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("seq_err_go_idle", seq_err, 1);

    // prepare dropped in READY aborts; a fresh fill needs the full settle again.
    fill_len = 5;
    prepare = 1'b1;
    wait_ready(r);
    prepare = 1'b0;
    tick();
    chk("abort_ready_low", ready, 0);
    tick();
    run_fill(2);

    // Reset during strobe 5 of a 16-sample fill.
    fill_len = 16;
    prepare = 1'b1;
    wait_ready(r);
    tick();
    go = 1'b1;
    prepare = 1'b0;
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(i);
    for (int i = 0; i < 100 && exp_addr_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_pre_strobes", exp_addr_q.size(), 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    go = 1'b0;
    exp_fill = 0;
    tick();
    rst = 1'b0;
    tick();
    run_fill(4);

    // Wrap: 17 fills since reset with a 4-bit counter reads 1.
    repeat (16) run_fill(1);
    chk("fill_num_wrap", fill_num, 1);

    tick();
    tick();
    chk("scoreboard_empty", exp_addr_q.size() + exp_fill_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
